bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Generates the active-low grant signals (mNGrnt_) that the bus master multiplexer consumes.
- Arbitrates four masters' active-low requests (mNReq_) using registered round-robin ownership.
- Exactly one grant is asserted at all times, so the downstream mux always has a defined owner.
- Sits beside the master mux on the shared bus; one instance per bus.

Parameters:
- TIMEOUT_CYCLES, 16, max consecutive cycles an owner may hold the bus while another master requests (used only with the optional feature); legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_  input  1  asynchronous reset, active-low
- m0Req_  input  1  master 0 bus request, active-low
- m1Req_  input  1  master 1 bus request, active-low
- m2Req_  input  1  master 2 bus request, active-low
- m3Req_  input  1  master 3 bus request, active-low
- m0Grnt_  output  1  master 0 grant, active-low, registered
- m1Grnt_  output  1  master 1 grant, active-low, registered
- m2Grnt_  output  1  master 2 grant, active-low, registered
- m3Grnt_  output  1  master 3 grant, active-low, registered
- owner  output  2  index of the current bus owner, registered

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: owner=0, m0Grnt_=0, m1Grnt_/m2Grnt_/m3Grnt_=1. Timeout counter=0 when the feature is compiled in.
- Invariant: exactly one mNGrnt_ low every cycle; the low grant index equals owner.
- State: owner register, encoding the states OWN0..OWN3.
- Grants are decoded from owner, either registered or as a direct decode of the owner flop; no combinational path from any mNReq_ to any mNGrnt_.
- Hold rule: while the owner's mNReq_=0, owner is unchanged.
- Release rule: when the owner's mNReq_=1, the next owner is the first requester searched in order owner+1, owner+2, owner+3 (mod 4).
  - If no master requests, owner is unchanged (parked grant).
- Latency:
  - A release seen at edge N makes the new grant visible after edge N.
  - A request from a non-owner is granted no earlier than 1 cycle after the owner releases.
- Simultaneous requests: resolved solely by the round-robin order relative to the current owner. No master waits more than 3 ownership changes.
- Owner re-request: a master that releases and re-asserts in the same cycle with no other requester keeps ownership. If other requesters exist, it loses ownership.
- Requests are sampled only at clk edges. Glitches between edges have no effect.
- Reset mid-operation: ownership returns to master 0 immediately (asynchronous), regardless of pending requests.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined: an 8-bit holdCnt counts cycles the current owner keeps its request asserted.
  - holdCnt clears on every owner change and when no other master requests.
  - When holdCnt == TIMEOUT_CYCLES-1 and at least one other master requests, the next edge forces rotation per the release-rule search, even though the owner still requests.
  - The preempted master re-enters normal round-robin.
- Undefined: no counter is instantiated; the owner holds the bus indefinitely while requesting.

Test Plan:
- Reset, no requests → owner=0, grants {m3..m0}=4'b1110, stable for 10 cycles.
- Owner 0 holds m0Req_=0; m2Req_=0 asserted → no change. Drop m0Req_ at edge N → owner=2 and m2Grnt_=0 after edge N.
- From owner=1, masters 0, 2 and 3 request and owner 1 releases → sequence 2, 3, 0 as each releases in turn. Exactly one grant low in every cycle (bench assertion).
- All requests deasserted from owner=3 → owner stays 3, m3Grnt_=0 parked.
- Assert reset_=0 mid-cycle while owner=2 → grants immediately become 4'b1110 without waiting for a clock edge.
- BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4:
  - m0 holds and m1 requests continuously → owner switches to 1 after 4 held cycles.
  - With m1 idle, m0 holds 50 cycles without preemption.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four active-low bus masters; exactly one active-low grant at all times.
// Optional owner preemption after TIMEOUT_CYCLES held cycles when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       m0Req_,
  input  logic       m1Req_,
  input  logic       m2Req_,
  input  logic       m3Req_,
  output logic       m0Grnt_,
  output logic       m1Grnt_,
  output logic       m2Grnt_,
  output logic       m3Grnt_,
  output logic [1:0] owner
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  logic [3:0] req;
  logic [1:0] owner_q, owner_d;
  logic [1:0] next_req;
  logic [1:0] idx;
  logic       own_req;
  logic       others_req;
  logic       rotate;

  assign req = ~{m3Req_, m2Req_, m1Req_, m0Req_};

  // Search owner+1, owner+2, owner+3; descending loop so the nearest requester wins.
  always_comb begin
    own_req    = req[owner_q];
    others_req = |(req & ~(4'b0001 << owner_q));
    next_req   = owner_q;
    idx        = owner_q;
    for (int i = 3; i >= 1; i--) begin
      idx = owner_q + 2'(i);
      if (req[idx]) begin
        next_req = idx;
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout;

  assign timeout = own_req && others_req && (hold_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign rotate  = others_req && (!own_req || timeout);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (owner_d != owner_q || !others_req) begin
      hold_cnt_d = 8'd0;
    end else if (own_req && hold_cnt_q != 8'hff) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign rotate = others_req && !own_req;
`endif

  always_comb begin
    owner_d = owner_q;
    if (rotate) begin
      owner_d = next_req;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      owner_q <= 2'd0;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Grants decode straight from the owner flop: no request-to-grant combinational path.
  assign m0Grnt_ = (owner_q != 2'd0);
  assign m1Grnt_ = (owner_q != 2'd1);
  assign m2Grnt_ = (owner_q != 2'd2);
  assign m3Grnt_ = (owner_q != 2'd3);
  assign owner   = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, hold/release, rotation order, parking, async reset
// and either timeout preemption (BUS_ARB_TIMEOUT_EN) or indefinite hold.
module tb_bus_arbiter;

  logic       clk;
  logic       reset_;
  logic       m0Req_, m1Req_, m2Req_, m3Req_;
  logic       m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_;
  logic [1:0] owner;
  logic [3:0] grnt;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .m0Req_ (m0Req_),
    .m1Req_ (m1Req_),
    .m2Req_ (m2Req_),
    .m3Req_ (m3Req_),
    .m0Grnt_(m0Grnt_),
    .m1Grnt_(m1Grnt_),
    .m2Grnt_(m2Grnt_),
    .m3Grnt_(m3Grnt_),
    .owner  (owner)
  );

  assign grnt = {m3Grnt_, m2Grnt_, m1Grnt_, m0Grnt_};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check owner and the grant vector it must imply.
  task automatic chk_own(input string tag, input logic [1:0] exp_owner);
    logic [3:0] exp_grnt;
    exp_grnt = ~(4'b0001 << exp_owner);
    chk({tag, "_owner"}, {2'b00, owner}, {2'b00, exp_owner});
    chk({tag, "_grnt"}, grnt, exp_grnt);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reqs given as {m3,m2,m1,m0} active-low
  task automatic set_req(input logic [3:0] r);
    {m3Req_, m2Req_, m1Req_, m0Req_} = r;
  endtask

  // Exactly one grant low, matching owner, every cycle out of reset.
  always @(negedge clk) begin
    if (reset_ === 1'b1) begin
      checks++;
      assert ($countones(~grnt) == 1 && grnt === ~(4'b0001 << owner))
      else begin
        errors++;
        $error("FAIL one_grant: observed grnt=%b owner=%0d", grnt, owner);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_ = 1'b0;
    set_req(4'b1111);
    #12;
    chk_own("reset", 2'd0);
    reset_ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_own("idle_park0", 2'd0);
    end

    // Owner 0 holds while m2 waits.
    set_req(4'b1010);
    step(3);
    chk_own("hold0", 2'd0);
    set_req(4'b1011);
    #3;
    chk_own("pre_release", 2'd0);
    step(1);
    chk_own("release_to2", 2'd2);

    // Move ownership to 1: m2 releases, m1 requests.
    set_req(4'b1101);
    step(1);
    chk_own("to1", 2'd1);

    // 0, 2, 3 request; 1 releases -> 2, 3, 0 as each releases.
    set_req(4'b0010);
    step(1);
    chk_own("rr_2", 2'd2);
    set_req(4'b0110);
    step(1);
    chk_own("rr_3", 2'd3);
    set_req(4'b1110);
    step(1);
    chk_own("rr_0", 2'd0);

    // Nobody requests: park on 0, then request from 3 only.
    set_req(4'b1111);
    step(2);
    chk_own("park0", 2'd0);
    set_req(4'b0111);
    step(1);
    chk_own("to3", 2'd3);
    set_req(4'b1111);
    step(5);
    chk_own("park3", 2'd3);

    // Simultaneous 0 and 2 from owner 3: nearest in order (0) wins.
    set_req(4'b1010);
    step(1);
    chk_own("simul_0", 2'd0);
    set_req(4'b1011);
    step(1);
    chk_own("then_2", 2'd2);

    // Async reset mid-cycle with owner 2 still requesting.
    #2;
    reset_ = 1'b0;
    #1;
    chk_own("async_reset", 2'd0);
    @(negedge clk);
    reset_ = 1'b1;
    step(1);
    chk_own("after_reset_to2", 2'd2);

    // Fresh start for the hold/timeout section with m0 holding.
    reset_ = 1'b0;
    set_req(4'b1110);
    #3;
    reset_ = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (i % 10 == 9) chk_own("hold_no_contender", 2'd0);
    end
    set_req(4'b1100);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_own("held_before_to", 2'd0);
    end
    step(1);
    chk_own("timeout_to1", 2'd1);
    // m1 now held; m0 still requests and eventually preempts back.
    step(3);
    chk_own("m1_held", 2'd1);
    step(1);
    chk_own("timeout_back0", 2'd0);
`else
    set_req(4'b1100);
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (i % 5 == 4) chk_own("hold_forever", 2'd0);
    end
    set_req(4'b1101);
    step(1);
    chk_own("release_to1", 2'd1);
`endif

    set_req(4'b1111);
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
